// File: rtl/placement_pkg.sv
// Shared definitions for the placement engine and its read-side evaluator:
// FSM encoding, error codes and the EMPTY sentinel used in the pos/grid memories.
package placement_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHK_POS,
    S_CHK_POS_W,
    S_CHK_GRID,
    S_CHK_GRID_W,
    S_CHK_CMP,
    S_EDGE_RD,
    S_EDGE_W,
    S_POSA_RD,
    S_POSA_W,
    S_POSB_RD,
    S_POSB_W,
    S_ACC,
    S_DONE
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_UNPLACED = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_GRID     = 2'd3;

  localparam logic signed [31:0] EMPTY = -32'sd1;

endpackage

// File: rtl/placement_evaluator_edge_cost.sv
// Combinational per-edge cost terms: |dx|+|dy|-1 and ceil(|dx|/2)+ceil(|dy|/2)-1.
// All values are DW-bit two's complement; results wrap like the accumulators.
module edge_cost
  import placement_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] ax,
  input  logic [DW-1:0] ay,
  input  logic [DW-1:0] bx,
  input  logic [DW-1:0] by,
  output logic [DW-1:0] term,
  output logic [DW-1:0] term_1hop
);

  logic [DW-1:0] dx, dy, adx, ady, hx, hy;

  always_comb begin
    dx  = ax - bx;
    dy  = ay - by;
    adx = dx[DW-1] ? (-dx) : dx;
    ady = dy[DW-1] ? (-dy) : dy;
    hx  = (adx >> 1) + {{(DW-1){1'b0}}, adx[0]};
    hy  = (ady >> 1) + {{(DW-1){1'b0}}, ady[0]};
    term      = adx + ady - DW'(1);
    term_1hop = hx + hy - DW'(1);
  end

endmodule

// File: rtl/placement_evaluator.sv
// Reads back pos/grid/edge memories, checks placement consistency, then sums wire costs.
// Every memory read has one wait state; start is ignored unless the FSM is idle.
module placement_evaluator
  import placement_pkg::*;
#(
  parameter int N_NODES = 5,
  parameter int GRID_N  = 5,
  parameter int N_EDGE  = 22,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err,
  output logic [DW-1:0] err_node,
  output logic [DW-1:0] cost,
  output logic [DW-1:0] cost_1hop,
  output logic          reEA,
  output logic [DW-1:0] addrEA,
  input  logic [DW-1:0] doutEA,
  output logic          reEB,
  output logic [DW-1:0] addrEB,
  input  logic [DW-1:0] doutEB,
  output logic          rePX,
  output logic [DW-1:0] addrPX,
  input  logic [DW-1:0] doutPX,
  output logic          rePY,
  output logic [DW-1:0] addrPY,
  input  logic [DW-1:0] doutPY,
  output logic          reGrid,
  output logic [DW-1:0] addrGrid,
  input  logic [DW-1:0] doutGrid
);

  state_t        state, state_nxt;
  logic [DW-1:0] idx;
  logic [DW-1:0] ea_q, eb_q, ax_q, ay_q;
  logic          fail_q;
  logic [DW-1:0] term, term_1hop;
  logic          last_node, last_edge, unplaced, out_range, grid_bad;

  assign last_node = (idx == DW'(N_NODES - 1));
  assign last_edge = (idx == DW'(N_EDGE - 1));
  assign unplaced  = (doutPX == DW'(EMPTY)) || (doutPY == DW'(EMPTY));
  // Unsigned compare also catches negative coordinates other than EMPTY.
  assign out_range = (doutPX >= DW'(GRID_N)) || (doutPY >= DW'(GRID_N));
  assign grid_bad  = (doutGrid != idx);

  edge_cost #(.DW(DW)) u_edge_cost (
    .ax        (ax_q),
    .ay        (ay_q),
    .bx        (doutPX),
    .by        (doutPY),
    .term      (term),
    .term_1hop (term_1hop)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (start) state_nxt = S_CHK_POS;
      S_CHK_POS:    state_nxt = S_CHK_POS_W;
      S_CHK_POS_W:  state_nxt = S_CHK_GRID;
      S_CHK_GRID:   state_nxt = S_CHK_GRID_W;
      S_CHK_GRID_W: state_nxt = S_CHK_CMP;
      // Range/unplaced failures still run out the node slot so failure latency is uniform.
      S_CHK_CMP: begin
        if (fail_q || grid_bad) state_nxt = S_DONE;
        else if (last_node)     state_nxt = S_EDGE_RD;
        else                    state_nxt = S_CHK_POS;
      end
      S_EDGE_RD:    state_nxt = S_EDGE_W;
      S_EDGE_W:     state_nxt = S_POSA_RD;
      S_POSA_RD:    state_nxt = S_POSA_W;
      S_POSA_W:     state_nxt = S_POSB_RD;
      S_POSB_RD:    state_nxt = S_POSB_W;
      S_POSB_W:     state_nxt = S_ACC;
      S_ACC:        state_nxt = last_edge ? S_DONE : S_EDGE_RD;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE) && (state != S_DONE);
    done     = (state == S_DONE);
    reEA     = 1'b0;
    reEB     = 1'b0;
    rePX     = 1'b0;
    rePY     = 1'b0;
    reGrid   = 1'b0;
    addrEA   = '0;
    addrEB   = '0;
    addrPX   = '0;
    addrPY   = '0;
    addrGrid = '0;
    case (state)
      S_CHK_POS: begin
        rePX   = 1'b1;
        rePY   = 1'b1;
        addrPX = idx;
        addrPY = idx;
      end
      S_CHK_GRID: begin
        if (!unplaced && !out_range) begin
          reGrid   = 1'b1;
          addrGrid = doutPX * DW'(GRID_N) + doutPY;
        end
      end
      S_EDGE_RD: begin
        reEA   = 1'b1;
        reEB   = 1'b1;
        addrEA = idx;
        addrEB = idx;
      end
      S_POSA_RD: begin
        rePX   = 1'b1;
        rePY   = 1'b1;
        addrPX = ea_q;
        addrPY = ea_q;
      end
      S_POSB_RD: begin
        rePX   = 1'b1;
        rePY   = 1'b1;
        addrPX = eb_q;
        addrPY = eb_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      fail_q    <= 1'b0;
      ea_q      <= '0;
      eb_q      <= '0;
      ax_q      <= '0;
      ay_q      <= '0;
      err       <= ERR_OK;
      err_node  <= '0;
      cost      <= '0;
      cost_1hop <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx       <= '0;
            fail_q    <= 1'b0;
            err       <= ERR_OK;
            err_node  <= '0;
            cost      <= '0;
            cost_1hop <= '0;
          end
        end
        S_CHK_GRID: begin
          if (unplaced) begin
            fail_q   <= 1'b1;
            err      <= ERR_UNPLACED;
            err_node <= idx;
          end else if (out_range) begin
            fail_q   <= 1'b1;
            err      <= ERR_RANGE;
            err_node <= idx;
          end
        end
        S_CHK_CMP: begin
          if (!fail_q) begin
            if (grid_bad) begin
              err      <= ERR_GRID;
              err_node <= idx;
            end else begin
              idx <= last_node ? '0 : idx + DW'(1);
            end
          end
        end
        S_EDGE_W: begin
          ea_q <= doutEA;
          eb_q <= doutEB;
        end
        S_POSB_RD: begin
          ax_q <= doutPX;
          ay_q <= doutPY;
        end
        S_ACC: begin
          cost      <= cost + term;
          cost_1hop <= cost_1hop + term_1hop;
          idx       <= idx + DW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/placement_evaluator.md
# placement_evaluator

Read-side checker for the placement memories. After a placement run has filled the pos_X, pos_Y and grid RAMs, this block reads them back together with the edge ROMs (ea, eb). It verifies that the placement is consistent, then computes the total wire cost and the 1-hop cost. It sits beside the placement engine and shares its memories through read-only ports, so cost reporting can be removed from the engine.

## Interface
Parameters:
- `N_NODES`, 5: number of nodes (pos RAM depth).
- `GRID_N`, 5: grid side; grid address = x*GRID_N+y.
- `N_EDGE`, 22: number of edges (ea/eb depth).
- `DW`, 32: data width of all memories and results.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request, accepted only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse; results are valid from this cycle.
- `err`  out  2  0 = ok, 1 = unplaced node, 2 = position out of range, 3 = grid mismatch.
- `err_node`  out  DW  node index that caused the error (0 if ok).
- `cost`  out  DW signed  sum over edges of |dx|+|dy|-1.
- `cost_1hop`  out  DW signed  sum over edges of ceil(|dx|/2)+ceil(|dy|/2)-1.
- `reEA`/`addrEA`/`doutEA`, `reEB`/`addrEB`/`doutEB`  out/out/in  1/DW/DW  edge ROM read ports.
- `rePX`/`addrPX`/`doutPX`, `rePY`/`addrPY`/`doutPY`  out/out/in  1/DW/DW  position RAM read ports.
- `reGrid`/`addrGrid`/`doutGrid`  out/out/in  1/DW/DW  grid RAM read port.

## Operation
- Memory read contract: `re` and `addr` are driven in cycle t; `dout` is sampled in cycle t+1 (one wait state). All `re*` strobes are single-cycle and are low in every other cycle.
- Check phase, for each node v = 0..N_NODES-1:
  - CHK_POS: read posX[v] and posY[v].
  - CHK_POS_W: wait.
  - CHK_GRID: if x = -1 or y = -1, fail with err = 1. If x or y is outside [0, GRID_N-1], fail with err = 2. Otherwise read grid[x*GRID_N+y].
  - CHK_GRID_W: wait.
  - CHK_CMP: if grid ≠ v, fail with err = 3; otherwise move to the next node.
- On any failure: set `err_node` = v, skip the edge phase, go to DONE. `cost` and `cost_1hop` stay 0.
- Edge phase, for each edge e = 0..N_EDGE-1:
  - EDGE_RD: read ea[e] and eb[e].
  - EDGE_W: wait.
  - POSA_RD: read the position of a.
  - POSA_W: wait.
  - POSB_RD: latch a's position and read the position of b.
  - POSB_W: wait.
  - ACC: latch b's position and accumulate both sums.
- Arithmetic:
  - dx and dy are DW-bit signed differences; absolute value is two's-complement negation when negative.
  - Half-ceil is (d>>1)+d[0].
  - Accumulators are DW signed and wrap on overflow with no saturation.
  - Per-edge terms can be -1 when a = b.
- DONE: pulse `done` for one cycle, drop `busy`, return to IDLE.
- `err`, `err_node`, `cost` and `cost_1hop` hold their values until the next accepted `start`. On that `start` they clear to 0.
- `start` while busy is ignored, with no restart and no queueing.
- Reset asserted mid-operation: the next state is IDLE and every output clears on that edge, including `busy` and `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `err_node`=0, `cost`=0, `cost_1hop`=0, all `re*`=0, all `addr*`=0.
- If `start` is sampled in IDLE at cycle t, then `busy`=1 from t+1.
- Latency on success: `done` is asserted at cycle t+1+5*N_NODES+7*N_EDGE.
- Latency on failure at node v: `done` is asserted at cycle t+1+5*(v+1).
- There is no wait state between nodes or between edges.

## Structure
- Shared package `placement_pkg`:
  - state encoding.
  - error codes `ERR_OK`, `ERR_UNPLACED`, `ERR_RANGE`, `ERR_GRID`.
  - the `EMPTY` = -1 sentinel, shared with the placement engine and the grid/pos init files.
- One sub-module, `edge_cost`: combinational. Takes (ax, ay, bx, by) and returns the two per-edge terms. It is instantiated once and fed by the ACC state.
- The FSM and accumulators stay in `placement_evaluator`.

## Test plan
- GRID_N=5, N_NODES=3, N_EDGE=2, edges (0,1) and (0,2), positions 0@(0,0), 1@(0,1), 2@(3,4), grid consistent; pulse `start` → `done` 1+15+14 = 30 cycles later, err=0, cost=6, cost_1hop=3.
- Same setup but posX[1] = -1 → err=1, err_node=1, cost=0, `done` at t+11.
- Same setup but grid[0*5+1] = 2 → err=3, err_node=1, `done` at t+11.
- Node 2 at (5,0) → err=2, err_node=2, and no grid read is issued for node 2.
- `start` pulsed again at t+5 of a run → ignored, and the results match the first scenario exactly.
- Active-low `reset` asserted at t+20 of a run → all outputs 0 on the next edge. A later `start` produces the results of the first scenario.
